// File: rtl/sprite_palette_pkg.sv
// Shared types and the power-on colour table for sprite_palette_bank.
package sprite_palette_pkg;

  localparam int RGB_CH_W = 4;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_e;

  // Entry 1 is the transparent key colour; the rest are a skin and clothing ramp.
  localparam rgb_t DEFAULT_PALETTE [16] = '{
    12'h000, 12'hF0F, 12'hFDB, 12'hEC9, 12'hDA7, 12'hB85, 12'h963, 12'h742,
    12'hF44, 12'hC22, 12'h811, 12'h48F, 12'h26C, 12'h149, 12'hFFF, 12'h888
  };

endpackage

// File: rtl/sprite_flash_ctrl.sv
// Frame-counted hit-flash sequencer: alternates FLASH_ON/FLASH_OFF every FLASH_PERIOD frame ticks.
module sprite_flash_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       flash_start,
  input  logic [7:0] flash_frames,
  output logic       flash_on,
  output logic       flash_active
);

  localparam int TICK_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  flash_state_e      state;
  logic [7:0]        remaining;
  logic [TICK_W-1:0] tick_cnt;

  // A zero-length start is ignored in every state; start beats a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= 8'd0;
      tick_cnt     <= '0;
      flash_active <= 1'b0;
    end else if (flash_start && (flash_frames != 8'd0)) begin
      state        <= FLASH_ON;
      remaining    <= flash_frames;
      tick_cnt     <= '0;
      flash_active <= 1'b1;
    end else if ((state != IDLE) && frame_tick) begin
      if (tick_cnt == TICK_W'(FLASH_PERIOD - 1)) begin
        tick_cnt  <= '0;
        remaining <= remaining - 8'd1;
        if (remaining == 8'd1) begin
          state        <= IDLE;
          flash_active <= 1'b0;
        end else begin
          state <= (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
        end
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  assign flash_on = (state == FLASH_ON);

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank runtime-writable sprite palette with a 2-stage lookup and write handshake.
// Define SPRITE_PALETTE_FLASH_EN to include the hit-flash sequencer and white override.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W           = 4,
  parameter int NUM_BANKS         = 4,
  parameter int CH_W              = 4,
  parameter int TRANSPARENT_INDEX = 1,
  parameter int FLASH_PERIOD      = 4,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid,
  input  logic [BANK_W-1:0]   bank_sel,
  input  logic [INDEX_W-1:0]  index,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                pix_valid_out,
  output logic                transparent,
  input  logic                wr_req,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0]   wr_data,
  output logic                wr_ack,
  input  logic                frame_tick,
  input  logic                flash_start,
  input  logic [7:0]          flash_frames,
  output logic                flash_active
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int RGB_W   = 3 * CH_W;

  logic [RGB_W-1:0]   mem [NUM_BANKS][ENTRIES];
  logic               s1_valid;
  logic [BANK_W-1:0]  s1_bank;
  logic [INDEX_W-1:0] s1_index;
  logic               wr_busy;
  logic               flash_on;
  logic [BANK_W-1:0]  rd_bank;
  logic               s1_is_transp;
  logic [RGB_W-1:0]   pix_rgb;

`ifdef SPRITE_PALETTE_FLASH_EN
  sprite_flash_ctrl #(.FLASH_PERIOD(FLASH_PERIOD)) u_flash (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .flash_start  (flash_start),
    .flash_frames (flash_frames),
    .flash_on     (flash_on),
    .flash_active (flash_active)
  );
`else
  logic unused_flash_inputs;
  assign unused_flash_inputs = ^{frame_tick, flash_start, flash_frames};
  assign flash_on     = 1'b0;
  assign flash_active = 1'b0;
`endif

  // Stage-2 read data: out-of-range banks alias to bank 0, flash whitens opaque pixels.
  always_comb begin
    rd_bank      = s1_bank;
    if (32'(s1_bank) >= NUM_BANKS) begin
      rd_bank = '0;
    end else begin
      rd_bank = s1_bank;
    end
    s1_is_transp = (s1_index == INDEX_W'(TRANSPARENT_INDEX));
    if (flash_on && !s1_is_transp) begin
      pix_rgb = '1;
    end else begin
      pix_rgb = mem[rd_bank][s1_index];
    end
  end

  // Palette storage and write handshake; wr_busy blocks re-acceptance until wr_req drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem[b][e] <= DEFAULT_PALETTE[e % 16];
        end
      end
      wr_ack  <= 1'b0;
      wr_busy <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      if (wr_req && !wr_busy) begin
        wr_ack  <= 1'b1;
        wr_busy <= 1'b1;
        if (32'(wr_bank) < NUM_BANKS) begin
          mem[wr_bank][wr_index] <= wr_data;
        end
      end else if (!wr_req) begin
        wr_busy <= 1'b0;
      end
    end
  end

  // Two-stage lookup; RGB holds across idle slots so the colour mux sees no glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_bank       <= '0;
      s1_index      <= '0;
      pix_valid_out <= 1'b0;
      transparent   <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
    end else begin
      s1_valid      <= pix_valid;
      s1_bank       <= bank_sel;
      s1_index      <= index;
      pix_valid_out <= s1_valid;
      transparent   <= s1_valid && s1_is_transp;
      if (s1_valid) begin
        {red, green, blue} <= pix_rgb;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: reference model predicts, negedge monitor compares.
module tb_sprite_palette_bank;
  import sprite_palette_pkg::*;

  localparam int NUM_BANKS = 4;
  localparam int TIDX      = 1;
  localparam int FP        = 4;
`ifdef SPRITE_PALETTE_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid, wr_req, frame_tick, flash_start;
  logic [1:0]  bank_sel, wr_bank;
  logic [3:0]  index, wr_index;
  logic [11:0] wr_data;
  logic [7:0]  flash_frames;
  logic [3:0]  red, green, blue;
  logic        pix_valid_out, transparent, wr_ack, flash_active;

  always #5 clk = ~clk;

  sprite_palette_bank dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .bank_sel(bank_sel), .index(index),
    .red(red), .green(green), .blue(blue), .pix_valid_out(pix_valid_out),
    .transparent(transparent), .wr_req(wr_req), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_data(wr_data), .wr_ack(wr_ack), .frame_tick(frame_tick), .flash_start(flash_start),
    .flash_frames(flash_frames), .flash_active(flash_active)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [12:0] pix_q [$];
  logic [1:0]  ctl_q [$];
  logic [11:0] mem_m [NUM_BANKS][16];
  logic        req_v;
  logic [1:0]  req_bank;
  logic [3:0]  req_idx;
  bit          wr_armed;
  bit          fl_act;
  int          fl_ticks, fl_total;
  bit          running = 1'b0;
  int          ack_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NUM_BANKS; b++)
      for (int e = 0; e < 16; e++) mem_m[b][e] = DEFAULT_PALETTE[e];
    req_v = 1'b0; req_bank = 2'd0; req_idx = 4'd0;
    wr_armed = 1'b1; fl_act = 1'b0; fl_ticks = 0; fl_total = 0;
    pix_q.delete(); ctl_q.delete();
  endtask

  // Applies the rules for one clock edge using the inputs that were stable at that edge.
  task automatic model_edge();
    bit          ack, fl_on;
    logic [11:0] v;
    fl_on = FLASH_EN && fl_act && (((fl_ticks / FP) % 2) == 0);
    if (req_v) begin
      v = mem_m[(req_bank < NUM_BANKS) ? req_bank : 2'd0][req_idx];
      if (fl_on && (req_idx != 4'(TIDX))) v = 12'hFFF;
      pix_q.push_back({v, req_idx == 4'(TIDX)});
    end
    ack = 1'b0;
    if (wr_req && wr_armed) begin
      ack = 1'b1;
      wr_armed = 1'b0;
      if (wr_bank < NUM_BANKS) mem_m[wr_bank][wr_index] = wr_data;
    end else if (!wr_req) begin
      wr_armed = 1'b1;
    end
    if (FLASH_EN) begin
      if (flash_start && (flash_frames != 8'd0)) begin
        fl_act = 1'b1; fl_ticks = 0; fl_total = int'(flash_frames) * FP;
      end else if (fl_act && frame_tick) begin
        fl_ticks++;
        if (fl_ticks >= fl_total) fl_act = 1'b0;
      end
    end
    ctl_q.push_back({ack, fl_act});
    req_v = pix_valid; req_bank = bank_sel; req_idx = index;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) model_edge();
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0; bank_sel = 2'd0; index = 4'd0;
    wr_req = 1'b0; wr_bank = 2'd0; wr_index = 4'd0; wr_data = 12'd0;
    frame_tick = 1'b0; flash_start = 1'b0; flash_frames = 8'd0;
  endtask

  task automatic read(input logic [1:0] b, input logic [3:0] i);
    pix_valid = 1'b1; bank_sel = b; index = i;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    check({tag, "_pvo"}, 32'(pix_valid_out), 32'd0);
    check({tag, "_transp"}, 32'(transparent), 32'd0);
    check({tag, "_ack"}, 32'(wr_ack), 32'd0);
    check({tag, "_flash_active"}, 32'(flash_active), 32'd0);
  endtask

  // Monitor: pops control expectations every cycle and pixel expectations on pix_valid_out.
  always @(negedge clk) begin
    logic [1:0]  c;
    logic [12:0] e;
    if (running && !rst) begin
      if (ctl_q.size() > 0) begin
        c = ctl_q.pop_front();
        check("wr_ack", 32'(wr_ack), 32'(c[1]));
        check("flash_active", 32'(flash_active), 32'(c[0]));
      end
      if (pix_valid_out === 1'b1) begin
        if (pix_q.size() == 0) begin
          check("unexpected_pix", 32'(pix_valid_out), 32'd0);
        end else begin
          e = pix_q.pop_front();
          check("rgb", 32'({red, green, blue}), 32'(e[12:1]));
          check("transparent", 32'(transparent), 32'(e[0]));
        end
      end else begin
        check("transparent_idle", 32'(transparent), 32'd0);
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();
    running = 1'b1;

    // First lookup: two-cycle latency, default colour of entry 0.
    read(2'd0, 4'd0); step();
    idle_inputs();
    check("lat1_pvo", 32'(pix_valid_out), 32'd0);
    step();
    check("lat2_pvo", 32'(pix_valid_out), 32'd1);
    check("lat2_rgb", 32'({red, green, blue}), 32'(12'h000));

    // Transparent index.
    read(2'd1, 4'd1); step(); idle_inputs(); step();
    check("transp_flag", 32'(transparent), 32'd1);
    check("transp_rgb", 32'({red, green, blue}), 32'(12'hF0F));
    step();

    // Write held three cycles with reads straddling the write edge.
    read(2'd2, 4'd5); step();
    wr_req = 1'b1; wr_bank = 2'd2; wr_index = 4'd5; wr_data = 12'h3A7;
    ack_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (wr_ack) ack_cnt++;
      if (k == 0) begin
        check("ack_after_req", 32'(wr_ack), 32'd1);
        check("collide_old", 32'({red, green, blue}), 32'(DEFAULT_PALETTE[5]));
      end
      if (k == 1) check("read_new", 32'({red, green, blue}), 32'(12'h3A7));
    end
    wr_req = 1'b0; pix_valid = 1'b0;
    step();
    if (wr_ack) ack_cnt++;
    check("single_ack", 32'(ack_cnt), 32'd1);

    // Flash sequence of three half-phases, reading an opaque and a transparent pixel.
    flash_start = 1'b1; flash_frames = 8'd3; read(2'd0, 4'd2);
    step();
    flash_start = 1'b0;
    check("flash_started", 32'(flash_active), 32'(FLASH_EN));
    for (int t = 0; t < 12; t++) begin
      frame_tick = 1'b1; read(2'd0, (t % 3 == 0) ? 4'd1 : 4'd2);
      step();
      if (t == 6) check("flash_mid", 32'(flash_active), 32'(FLASH_EN));
    end
    idle_inputs(); step(); step();
    check("flash_done", 32'(flash_active), 32'd0);

    // Reset mid-flash with a pending write to bank 3 entry 7.
    flash_start = 1'b1; flash_frames = 8'd2; step();
    flash_start = 1'b0;
    wr_req = 1'b1; wr_bank = 2'd3; wr_index = 4'd7; wr_data = 12'h123; read(2'd0, 4'd0);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge clk); #1;
    check_all_zero("midrst_hold");
    idle_inputs();
    rst = 1'b0;
    model_reset();
    read(2'd3, 4'd7); step(); idle_inputs(); step();
    check("entry_unchanged", 32'({red, green, blue}), 32'(DEFAULT_PALETTE[7]));

    // Randomized traffic with a well-behaved write requester.
    for (int i = 0; i < 600; i++) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      bank_sel = 2'($urandom); index = 4'($urandom);
      if (wr_req && wr_ack && ($urandom_range(0, 3) != 0)) begin
        wr_req = 1'b0;
      end else if (!wr_req && ($urandom_range(0, 3) == 0)) begin
        wr_req = 1'b1; wr_bank = 2'($urandom); wr_index = 4'($urandom); wr_data = 12'($urandom);
      end
      frame_tick = ($urandom_range(0, 2) == 0);
      flash_start = ($urandom_range(0, 40) == 0);
      flash_frames = 8'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    repeat (4) step();
    check("pix_q_drained", 32'(pix_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Multi-bank, runtime-writable colour lookup for sprite pixels. Maps a sprite's colour index plus a bank select to 12-bit RGB.
- Sits between the sprite ROM index fetch and the VGA colour mux. Each character/player selects its own bank, so one sprite sheet serves several colour schemes.
- Adds a registered 2-stage lookup, a transparency flag, a write port with handshake, and a frame-counted hit-flash effect.

Parameters:
- INDEX_W, 4: colour index width; entries per bank = 2**INDEX_W.
- NUM_BANKS, 4: number of palettes; bank select width BANK_W = $clog2(NUM_BANKS), minimum 1.
- CH_W, 4: bits per colour channel.
- TRANSPARENT_INDEX, 1: index reported as transparent, regardless of its stored colour.
- FLASH_PERIOD, 4: frame ticks per flash half-phase.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: asynchronous, active-high reset.
- pix_valid, in, 1: lookup request this cycle.
- bank_sel, in, BANK_W: palette bank to read.
- index, in, INDEX_W: colour index to read.
- red, out, CH_W: looked-up red channel.
- green, out, CH_W: looked-up green channel.
- blue, out, CH_W: looked-up blue channel.
- pix_valid_out, out, 1: pix_valid delayed by 2 cycles.
- transparent, out, 1: output pixel is the transparent index; qualified by pix_valid_out.
- wr_req, in, 1: palette write request.
- wr_bank, in, BANK_W: bank to write.
- wr_index, in, INDEX_W: entry to write.
- wr_data, in, 3*CH_W: colour to write, packed {r,g,b}.
- wr_ack, out, 1: one-cycle write acknowledge.
- frame_tick, in, 1: one-cycle pulse per frame (vsync edge).
- flash_start, in, 1: start a flash sequence.
- flash_frames, in, 8: number of flash half-phases to run.
- flash_active, out, 1: a flash sequence is in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - Every bank loads DEFAULT_PALETTE from the package.
  - red/green/blue = 0; pix_valid_out = 0; transparent = 0; wr_ack = 0; flash_active = 0.
  - FSM goes to IDLE; all counters = 0.
  - Asserting Reset mid-flash or mid-write aborts it; a pending write is not applied.
- Lookup pipeline, latency 2 cycles, one pixel per cycle, no stall:
  - S1 registers bank_sel, index, pix_valid.
  - S2 registers array[S1.bank][S1.index] to RGB, S1.index==TRANSPARENT_INDEX to transparent, and S1.valid to pix_valid_out.
  - When the S1 valid bit is 0, RGB holds its previous value and transparent = 0.
  - bank_sel >= NUM_BANKS (non-power-of-2 NUM_BANKS only) reads bank 0.
- Write port:
  - wr_req is sampled each cycle. On the next edge the entry is written and wr_ack pulses for 1 cycle (visible the cycle after the request).
  - Requester holds wr_req until it sees wr_ack. A wr_req still high in the ack cycle does not cause a second write; at most one write per 2 cycles.
  - Same-entry read/write collision: an S2 read in the same edge as the write returns the old value (read-before-write). The new value is seen from the next edge on.
  - wr_bank out of range: write dropped, wr_ack still pulses.
- Flash FSM:
  - States: IDLE, FLASH_ON, FLASH_OFF.
  - IDLE, on flash_start with flash_frames != 0: latch remaining = flash_frames, tick_cnt = 0, go to FLASH_ON.
  - IDLE, on flash_start with flash_frames == 0: ignored.
  - FLASH_ON / FLASH_OFF: tick_cnt increments on frame_tick. When it reaches FLASH_PERIOD-1 and a tick arrives: tick_cnt = 0, remaining decrements, toggle ON<->OFF. When remaining reaches 0, go to IDLE instead of toggling.
  - flash_start while not IDLE reloads remaining and tick_cnt and goes to FLASH_ON (retrigger).
  - flash_active = (state != IDLE), registered.
  - In FLASH_ON, S2 outputs all-ones RGB for non-transparent pixels; transparent pixels are unaffected.
  - frame_tick and flash_start in the same cycle: flash_start wins.

Optional Feature:
- Macro: SPRITE_PALETTE_FLASH_EN.
- Defined: flash FSM and flash override present as described.
- Undefined: no flash FSM or override; flash_active is tied to 0; flash_start, flash_frames and frame_tick are ignored. Lookup and write behaviour are unchanged.

Decomposition:
- Package sprite_palette_pkg holds:
  - rgb_t, a packed struct {r,g,b} of CH_W each.
  - flash_state_e: IDLE, FLASH_ON, FLASH_OFF.
  - DEFAULT_PALETTE, 16 entries of rgb_t: index 1 = 12'hF0F (transparent magenta), the rest a skin/clothing ramp.
- One sub-module: sprite_flash_ctrl, containing the FSM and counters, instantiated under the macro.

Test Plan:
- Reset, then pix_valid=1, bank 0, index 0 -> 2 cycles later RGB = DEFAULT_PALETTE[0], pix_valid_out=1, transparent=0.
- Index 1 read -> transparent=1 exactly 2 cycles after request, with RGB = 12'hF0F.
- wr_req bank 2, index 5, data 12'h3A7, held 3 cycles -> single wr_ack 1 cycle after the request. A read of (2,5) in the write edge returns the old value; a read the next cycle returns 12'h3A7.
- flash_start with flash_frames=3, FLASH_PERIOD=4 -> RGB forced to 12'hFFF for ticks 0-3, normal for 4-7, forced for 8-11, then IDLE with flash_active=0.
- Reset asserted during FLASH_ON with wr_req pending -> all outputs 0 immediately, no wr_ack, entry unchanged.
- Macro undefined: flash_start=1 -> flash_active stays 0 and RGB is never overridden.
